// File: rtl/line_buffer_ctrl.sv
// Row-buffer controller for a 3x3 window: ping-pong write enables and addresses, plus a read address with a fixed lead.
// Latency: every output is registered one cycle after the sampled vsync/VDE/switch inputs.
// Backpressure: none. The pixel stream is free-running; pixels past the buffer depth are dropped and flagged.
module line_buffer_ctrl #(
  parameter int   ADDR_WIDTH = 12,
  parameter int   ROW_WIDTH  = 11,
  parameter int   RD_LEAD    = 2,
  parameter int   MODE_WIDTH = 4,
  parameter logic VSYNC_POL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  input  logic [MODE_WIDTH-1:0] i_sw,
  output logic                  o_wea0,
  output logic                  o_wea1,
  output logic [ADDR_WIDTH-1:0] o_addra,
  output logic [ADDR_WIDTH-1:0] o_addrb,
  output logic                  o_row_sel,
  output logic [ADDR_WIDTH-1:0] o_col,
  output logic [ROW_WIDTH-1:0]  o_row,
  output logic [ADDR_WIDTH-1:0] o_line_width,
  output logic                  o_win_valid,
  output logic                  o_frame_start,
  output logic [MODE_WIDTH-1:0] o_mode,
  output logic                  o_ovf
);

  localparam logic [1:0] S_WAIT_FRAME = 2'd0;
  localparam logic [1:0] S_LINE_IDLE  = 2'd1;
  localparam logic [1:0] S_ACTIVE     = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] COL_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] COL_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] COL_TWO  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] COL_LEAD = ADDR_WIDTH'(RD_LEAD);
  localparam logic [ROW_WIDTH-1:0]  ROW_MAX  = '1;
  localparam logic [ROW_WIDTH-1:0]  ROW_ONE  = ROW_WIDTH'(1);

  // Internal state
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_WIDTH-1:0]  row_cnt_q, row_cnt_d;
  logic [1:0]            rows_filled_q, rows_filled_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  vsync_q;
  logic                  line_ovf_q, line_ovf_d;

  // Registered outputs
  logic                  wea0_q, wea0_d, wea1_q, wea1_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic                  row_sel_q, row_sel_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [ADDR_WIDTH-1:0] line_width_q, line_width_d;
  logic                  win_valid_q, win_valid_d;
  logic                  frame_start_q, frame_start_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic                  ovf_q, ovf_d;

  // Values after the frame reset has been applied. A pixel arriving with
  // the frame-start edge is therefore treated as column 0 of row 0.
  logic                  frame_start;
  logic [1:0]            eff_state;
  logic [ADDR_WIDTH-1:0] eff_col;
  logic [ROW_WIDTH-1:0]  eff_row;
  logic [1:0]            eff_filled;
  logic                  eff_sel;
  logic                  eff_line_ovf;

  // Next-state logic: frame reset first, then pixel or line-end handling
  always_comb begin
    frame_start  = (i_vid_vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    eff_state    = frame_start ? S_LINE_IDLE : state_q;
    eff_col      = frame_start ? '0 : col_cnt_q;
    eff_row      = frame_start ? '0 : row_cnt_q;
    eff_filled   = frame_start ? 2'd0 : rows_filled_q;
    eff_sel      = frame_start ? 1'b0 : wr_sel_q;
    eff_line_ovf = frame_start ? 1'b0 : line_ovf_q;

    state_d       = eff_state;
    col_cnt_d     = eff_col;
    row_cnt_d     = eff_row;
    rows_filled_d = eff_filled;
    wr_sel_d      = eff_sel;
    line_ovf_d    = eff_line_ovf;

    wea0_d        = 1'b0;
    wea1_d        = 1'b0;
    win_valid_d   = 1'b0;
    frame_start_d = frame_start;
    addra_d       = addra_q;
    addrb_d       = addrb_q;
    row_sel_d     = row_sel_q;
    col_d         = col_q;
    row_d         = row_q;
    line_width_d  = line_width_q;
    mode_d        = frame_start ? i_sw : mode_q;
    ovf_d         = frame_start ? 1'b0 : ovf_q;

    if ((eff_state != S_WAIT_FRAME) && i_vid_VDE) begin
      state_d     = S_ACTIVE;
      win_valid_d = (eff_filled == 2'd2) && (eff_col >= COL_TWO);
      if (eff_line_ovf) begin
        // Line already reached the last buffer slot: drop the pixel
        ovf_d = 1'b1;
      end else begin
        wea0_d  = ~eff_sel;
        wea1_d  = eff_sel;
        addra_d = eff_col;
        addrb_d = eff_col + COL_LEAD;
        col_d   = eff_col;
        row_d   = eff_row;
        if (eff_col == COL_MAX) begin
          line_ovf_d = 1'b1;
        end else begin
          col_cnt_d = eff_col + COL_ONE;
        end
      end
    end else if ((eff_state == S_ACTIVE) && !i_vid_VDE) begin
      // Line end: publish the finished row and flip the ping-pong buffer
      state_d      = S_LINE_IDLE;
      line_width_d = col_cnt_q;
      row_sel_d    = wr_sel_q;
      wr_sel_d     = ~wr_sel_q;
      col_cnt_d    = '0;
      line_ovf_d   = 1'b0;
      if (row_cnt_q != ROW_MAX) row_cnt_d = row_cnt_q + ROW_ONE;
      if (rows_filled_q != 2'd2) rows_filled_d = rows_filled_q + 2'd1;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_WAIT_FRAME;
      col_cnt_q     <= '0;
      row_cnt_q     <= '0;
      rows_filled_q <= 2'd0;
      wr_sel_q      <= 1'b0;
      vsync_q       <= ~VSYNC_POL;
      line_ovf_q    <= 1'b0;
      wea0_q        <= 1'b0;
      wea1_q        <= 1'b0;
      addra_q       <= '0;
      addrb_q       <= '0;
      row_sel_q     <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_width_q  <= '0;
      win_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      mode_q        <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      row_cnt_q     <= row_cnt_d;
      rows_filled_q <= rows_filled_d;
      wr_sel_q      <= wr_sel_d;
      vsync_q       <= i_vid_vsync;
      line_ovf_q    <= line_ovf_d;
      wea0_q        <= wea0_d;
      wea1_q        <= wea1_d;
      addra_q       <= addra_d;
      addrb_q       <= addrb_d;
      row_sel_q     <= row_sel_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_width_q  <= line_width_d;
      win_valid_q   <= win_valid_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      ovf_q         <= ovf_d;
    end
  end

  assign o_wea0        = wea0_q;
  assign o_wea1        = wea1_q;
  assign o_addra       = addra_q;
  assign o_addrb       = addrb_q;
  assign o_row_sel     = row_sel_q;
  assign o_col         = col_q;
  assign o_row         = row_q;
  assign o_line_width  = line_width_q;
  assign o_win_valid   = win_valid_q;
  assign o_frame_start = frame_start_q;
  assign o_mode        = mode_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: a default-sized instance plus a 3-bit-address instance for overflow.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point, one cycle after the pixel.
// Both instances share all inputs.
module tb_line_buffer_ctrl;

  logic       clk;
  logic       n_rst;
  logic       i_vid_vsync;
  logic       i_vid_VDE;
  logic [3:0] i_sw;

  logic        o_wea0, o_wea1, o_row_sel, o_win_valid, o_frame_start, o_ovf;
  logic [11:0] o_addra, o_addrb, o_col, o_line_width;
  logic [10:0] o_row;
  logic [3:0]  o_mode;

  logic        s_wea0, s_wea1, s_row_sel, s_win_valid, s_frame_start, s_ovf;
  logic [2:0]  s_addra, s_addrb, s_col, s_line_width;
  logic [10:0] s_row;
  logic [3:0]  s_mode;

  int checks = 0;
  int errors = 0;

  line_buffer_ctrl dut (
    .clk(clk), .n_rst(n_rst), .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE), .i_sw(i_sw),
    .o_wea0(o_wea0), .o_wea1(o_wea1), .o_addra(o_addra), .o_addrb(o_addrb),
    .o_row_sel(o_row_sel), .o_col(o_col), .o_row(o_row), .o_line_width(o_line_width),
    .o_win_valid(o_win_valid), .o_frame_start(o_frame_start), .o_mode(o_mode), .o_ovf(o_ovf)
  );

  line_buffer_ctrl #(.ADDR_WIDTH(3)) dut_s (
    .clk(clk), .n_rst(n_rst), .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE), .i_sw(i_sw),
    .o_wea0(s_wea0), .o_wea1(s_wea1), .o_addra(s_addra), .o_addrb(s_addrb),
    .o_row_sel(s_row_sel), .o_col(s_col), .o_row(s_row), .o_line_width(s_line_width),
    .o_win_valid(s_win_valid), .o_frame_start(s_frame_start), .o_mode(s_mode), .o_ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vsync rising edge with VDE low; expects a one-cycle frame_start pulse
  task automatic frame_edge(input logic [3:0] exp_mode);
    i_vid_VDE   = 1'b0;
    i_vid_vsync = 1'b1;
    tick();
    chk("fs_pulse", o_frame_start, 1);
    chk("mode_at_fs", o_mode, exp_mode);
    tick();
    chk("fs_one_cycle", o_frame_start, 0);
    i_vid_vsync = 1'b0;
    tick();
  endtask

  // One 8-pixel line on the default instance, checked pixel by pixel
  task automatic do_line(input int row);
    for (int c = 0; c < 8; c++) begin
      i_vid_VDE = 1'b1;
      tick();
      chk("wea0", o_wea0, (row % 2 == 0) ? 1 : 0);
      chk("wea1", o_wea1, (row % 2 == 1) ? 1 : 0);
      chk("addra", o_addra, c);
      chk("addrb", o_addrb, c + 2);
      chk("col", o_col, c);
      chk("row", o_row, row);
      chk("win_valid", o_win_valid, (row >= 2 && c >= 2) ? 1 : 0);
    end
  endtask

  // Line end followed by a 4-cycle gap
  task automatic line_end(input int row);
    i_vid_VDE = 1'b0;
    tick();
    chk("row_sel", o_row_sel, row % 2);
    chk("line_width", o_line_width, 8);
    chk("wea_gap", {o_wea0, o_wea1}, 0);
    repeat (3) tick();
  endtask

  initial begin
    n_rst       = 1'b0;
    i_vid_vsync = 1'b0;
    i_vid_VDE   = 1'b0;
    i_sw        = 4'b0011;
    repeat (3) tick();

    // Reset state
    chk("rst_wea", {o_wea0, o_wea1}, 0);
    chk("rst_addra", o_addra, 0);
    chk("rst_addrb", o_addrb, 0);
    chk("rst_fs", o_frame_start, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_win", o_win_valid, 0);
    chk("rst_row", o_row, 0);

    // Video before any frame start is ignored
    n_rst = 1'b1;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 8; c++) begin
        i_vid_VDE = 1'b1;
        tick();
        chk("nofs_wea", {o_wea0, o_wea1, s_wea0, s_wea1}, 0);
        chk("nofs_fs", o_frame_start, 0);
      end
      i_vid_VDE = 1'b0;
      repeat (4) tick();
    end

    // First frame, mode latched as 3
    frame_edge(4'd3);
    do_line(0);
    line_end(0);
    do_line(1);
    line_end(1);
    i_sw = 4'b0101;
    do_line(2);
    line_end(2);
    chk("mode_hold", o_mode, 3);
    do_line(3);
    line_end(3);
    chk("mode_hold2", o_mode, 3);

    // New frame picks up the changed switches
    frame_edge(4'd5);

    // Overflow on the 3-bit-address instance: 10 pixels into 8 slots
    for (int c = 0; c < 10; c++) begin
      i_vid_VDE = 1'b1;
      tick();
      if (c < 8) begin
        chk("ovf_wea0", s_wea0, 1);
        chk("ovf_addra", s_addra, c);
        chk("ovf_flag_lo", s_ovf, 0);
      end else begin
        chk("ovf_drop", {s_wea0, s_wea1}, 0);
        chk("ovf_flag_hi", s_ovf, 1);
      end
    end
    i_vid_VDE = 1'b0;
    tick();
    chk("ovf_line_width", s_line_width, 7);
    chk("ovf_sticky", s_ovf, 1);
    repeat (3) tick();
    frame_edge(4'd5);
    chk("ovf_cleared", s_ovf, 0);

    // vsync edge coincident with a line end: line-end bookkeeping discarded
    do_line(0);
    line_end(0);
    do_line(1);
    i_vid_VDE   = 1'b0;
    i_vid_vsync = 1'b1;
    tick();
    chk("sim_end_fs", o_frame_start, 1);
    chk("sim_end_row_sel", o_row_sel, 0);
    i_vid_vsync = 1'b0;
    repeat (3) tick();
    do_line(0);
    line_end(0);

    // vsync edge coincident with the first pixel of a line
    i_vid_VDE   = 1'b1;
    i_vid_vsync = 1'b1;
    tick();
    chk("sim_px_fs", o_frame_start, 1);
    chk("sim_px_wea0", o_wea0, 1);
    chk("sim_px_wea1", o_wea1, 0);
    chk("sim_px_col", o_col, 0);
    chk("sim_px_row", o_row, 0);
    i_vid_vsync = 1'b0;
    tick();
    chk("sim_px2_wea0", o_wea0, 1);
    chk("sim_px2_col", o_col, 1);

    // Mid-line reset drops the write enable without waiting for a clock
    n_rst = 1'b0;
    #1;
    chk("arst_wea", {o_wea0, o_wea1}, 0);
    #2;
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_wea", {o_wea0, o_wea1}, 0);
    end
    i_vid_VDE = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Controller for the 3x3 window datapath's two ping-pong row-buffer BRAMs. It derives column and row position from VDE and vsync, and generates the write enables and addresses for both buffers.
- It also generates the read address with a fixed lead for BRAM latency, and tells the datapath which buffer holds the newest row.
- It reports when the 3x3 window holds valid pixels.
- It latches the filter mode from the switches at frame boundaries only. This stops the output from tearing mid-frame.

Parameters:
- ADDR_WIDTH, 12, BRAM address width; maximum line length is 2^ADDR_WIDTH pixels.
- ROW_WIDTH, 11, row counter width.
- RD_LEAD, 2, read address lead over write address, in pixels.
- MODE_WIDTH, 4, switch/mode width.
- VSYNC_POL, 1, active level of i_vid_vsync.

Ports:
- clk  in  1  pixel clock
- n_rst  in  1  reset, asynchronous, active-low
- i_vid_vsync  in  1  frame sync from the video input
- i_vid_VDE  in  1  active-video qualifier
- i_sw  in  MODE_WIDTH  raw mode switches
- o_wea0  out  1  write enable, row buffer 0
- o_wea1  out  1  write enable, row buffer 1
- o_addra  out  ADDR_WIDTH  write address, shared by both buffers
- o_addrb  out  ADDR_WIDTH  read address, shared by both buffers
- o_row_sel  out  1  buffer holding the most recently completed row (0/1)
- o_col  out  ADDR_WIDTH  column of the current pixel
- o_row  out  ROW_WIDTH  row of the current pixel
- o_line_width  out  ADDR_WIDTH  pixel count of the last completed line
- o_win_valid  out  1  3x3 window is fully populated for this pixel
- o_frame_start  out  1  one-cycle pulse at vsync active edge
- o_mode  out  MODE_WIDTH  frame-synchronous mode
- o_ovf  out  1  sticky: line exceeded buffer depth this frame

Behaviour:
- Reset (async, n_rst=0):
  - all outputs 0; state WAIT_FRAME; col_cnt=0; row_cnt=0; rows_filled=0; wr_sel=0; vsync_d=~VSYNC_POL.
- Latency:
  - All outputs are registered, one cycle after the sampled inputs.
  - The datapath delays i_vid_data one register stage to align with o_wea*/o_addra.
- Frame start:
  - Trigger: vsync active edge, i.e. (i_vid_vsync==VSYNC_POL) && (vsync_d!=VSYNC_POL).
  - Actions: o_frame_start=1 for one cycle; o_mode<=i_sw; col_cnt, row_cnt, rows_filled, wr_sel, o_ovf cleared; state->LINE_IDLE.
  - o_mode changes at no other time.
- States:
  - WAIT_FRAME: after reset until the first frame start. VDE is ignored; no writes; o_win_valid=0.
  - LINE_IDLE: VDE=1 -> ACTIVE, and that pixel is column 0.
  - ACTIVE, on each VDE=1 cycle:
    - o_addra<=col_cnt; o_col<=col_cnt; o_row<=row_cnt.
    - o_addrb<=(col_cnt+RD_LEAD) mod 2^ADDR_WIDTH.
    - o_wea0<=~wr_sel; o_wea1<=wr_sel.
    - col_cnt<=col_cnt+1.
  - ACTIVE, VDE=0 (line end) -> LINE_IDLE:
    - o_line_width<=col_cnt; o_row_sel<=wr_sel; wr_sel toggles; col_cnt<=0.
    - row_cnt+1, saturating at all-ones.
    - rows_filled+1, saturating at 2.
- Write enables:
  - o_wea0/o_wea1 are never both 1.
  - Both are 0 on any cycle not driven by a VDE=1 pixel in ACTIVE.
- Window valid:
  - o_win_valid<=1 iff VDE=1 in ACTIVE, rows_filled==2, and col_cnt>=2. Otherwise 0.
- Overflow:
  - Trigger: col_cnt == 2^ADDR_WIDTH-1 and VDE=1.
  - That pixel is written normally. Later pixels in the same line: col_cnt holds, o_wea*=0, o_ovf<=1.
  - o_ovf stays set until the next frame start or reset.
  - o_line_width reports 2^ADDR_WIDTH-1 for that line.
- Simultaneous events:
  - Frame start with VDE=1: frame reset applies first, and the pixel is written as column 0 of row 0 to buffer 0.
  - Frame start with a line end: line-end bookkeeping is discarded and frame reset values win.
- Switch changes:
  - i_sw changes mid-frame have no effect on o_mode.
- Reset mid-line:
  - All state returns to reset values immediately, and any write enable drops asynchronously.
  - No writes occur until the next frame start.

Test Plan:
- Reset, then 3 lines of VDE=1 x8 with no vsync -> o_wea0=o_wea1=0 throughout; o_frame_start never pulses.
- vsync edge, then lines of 8 pixels separated by 4-cycle gaps:
  - Line 0 writes buffer 0, addresses 0..7, one cycle after each VDE.
  - Line 1 writes buffer 1; line 2 writes buffer 0.
  - o_row_sel=0 after line 0 and =1 after line 1; o_line_width=8.
  - o_addrb = o_addra+2.
- Same stimulus -> o_win_valid=0 on rows 0-1. On row 2 it is 0 for cols 0-1 and 1 for cols 2..7.
- i_sw=4'b0101 mid-frame, then a vsync edge -> o_mode stays at its old value until the edge, then becomes 5 with o_frame_start high for exactly one cycle.
- ADDR_WIDTH=3, line of 10 pixels:
  - Addresses 0..7 written, then o_wea*=0 for 2 cycles; o_ovf=1; o_line_width=7.
  - o_ovf clears at the next vsync edge.
- Simultaneous cases and mid-line reset:
  - vsync edge coincident with a VDE falling edge -> o_row=0, rows_filled=0, next line written to buffer 0.
  - vsync edge coincident with a first VDE pixel -> that pixel is col 0, row 0, o_wea0=1.
  - n_rst pulled low mid-line -> o_wea* drop to 0 immediately.
